// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-master block-RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned AW_DEF     = 8;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned RD_LAT_DEF = 1;

    typedef logic port_id_t;

    localparam port_id_t M0 = 1'b0;
    localparam port_id_t M1 = 1'b1;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return tag pipeline: delays {valid, id} by RD_LAT clocks to match RAM read latency.
module ram_arb_rd_pipe
    import ram_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_due
);

    rd_tag_t stage [RD_LAT];

    // Async clear drops any in-flight read so no response is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_due = stage[RD_LAT-1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter in front of a single-port block RAM; one access per clock.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (master 0 wins) instead of round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic          clka,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta
);

    logic    gnt0_c;
    logic    gnt1_c;
    rd_tag_t tag_in;
    rd_tag_t tag_due;

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Master 0 always wins a contest; master 1 may starve during boot load.
    always_comb begin
        gnt0_c = rst_n & m0_req;
        gnt1_c = rst_n & m1_req & ~m0_req;
    end
`else
    port_id_t last_grant;

    // Grant is combinational so the winner completes in the same cycle it requests.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                gnt0_c = (last_grant == M1);
                gnt1_c = (last_grant == M0);
            end else begin
                gnt0_c = m0_req;
                gnt1_c = m1_req;
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= M1;
        end else if (gnt0_c) begin
            last_grant <= M0;
        end else if (gnt1_c) begin
            last_grant <= M1;
        end
    end
`endif

    assign m0_gnt = gnt0_c;
    assign m1_gnt = gnt1_c;

    // RAM port follows the winner; parked at zero when idle.
    always_comb begin
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        if (gnt0_c) begin
            ram_wea   = m0_we;
            ram_addra = m0_addr;
            ram_dina  = m0_wdata;
        end else if (gnt1_c) begin
            ram_wea   = m1_we;
            ram_addra = m1_addr;
            ram_dina  = m1_wdata;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (gnt0_c & ~m0_we) | (gnt1_c & ~m1_we);
        tag_in.id    = gnt1_c ? M1 : M0;
    end

    ram_arb_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clka),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_due (tag_due)
    );

    assign m0_rvalid = tag_due.valid & (tag_due.id == M0);
    assign m1_rvalid = tag_due.valid & (tag_due.id == M1);
    assign m0_rdata  = ram_douta;
    assign m1_rdata  = ram_douta;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: one instance with RD_LAT=1 and one with RD_LAT=2, shared stimulus.
module tb_ram_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clka = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic       a_m0_gnt, a_m1_gnt, a_m0_rvalid, a_m1_rvalid, a_ram_wea;
    logic [7:0] a_m0_rdata, a_m1_rdata, a_ram_addra, a_ram_dina, a_ram_douta;
    logic       b_m0_gnt, b_m1_gnt, b_m0_rvalid, b_m1_rvalid, b_ram_wea;
    logic [7:0] b_m0_rdata, b_m1_rdata, b_ram_addra, b_ram_dina, b_ram_douta;

    always #5 clka = ~clka;

    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut_a (
        .clka(clka), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .ram_wea(a_ram_wea), .ram_addra(a_ram_addra), .ram_dina(a_ram_dina),
        .ram_douta(a_ram_douta)
    );

    ram_arbiter #(.AW(8), .DW(8), .RD_LAT(2)) dut_b (
        .clka(clka), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_wea(b_ram_wea), .ram_addra(b_ram_addra), .ram_dina(b_ram_dina),
        .ram_douta(b_ram_douta)
    );

    // Behavioural block RAMs: 1-clock and 2-clock read latency.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rb1;

    always @(posedge clka) begin
        if (a_ram_wea) mem_a[a_ram_addra] <= a_ram_dina;
        if (b_ram_wea) mem_b[b_ram_addra] <= b_ram_dina;
        a_ram_douta <= mem_a[a_ram_addra];
        rb1         <= mem_b[b_ram_addra];
        b_ram_douta <= rb1;
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    // Queue index: 0 = a.m0, 1 = a.m1, 2 = b.m0, 3 = b.m1
    exp_t q [4][$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic       rv [4];
    logic [7:0] rd [4];
    always_comb begin
        rv[0] = a_m0_rvalid; rd[0] = a_m0_rdata;
        rv[1] = a_m1_rvalid; rd[1] = a_m1_rdata;
        rv[2] = b_m0_rvalid; rd[2] = b_m0_rdata;
        rv[3] = b_m1_rvalid; rd[3] = b_m1_rdata;
    end

    // Monitor: every rvalid pops the oldest expected response for that port.
    always @(negedge clka) begin
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (rv[i] !== 1'b0) begin
                if (q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rvalid[%0d]: unexpected response data %0h, expected none (cycle %0d)",
                             i, rd[i], cyc);
                end else begin
                    e = q[i].pop_front();
                    chk($sformatf("rdata[%0d]", i), 32'(rd[i]), 32'(e.data));
                    chk($sformatf("rdue[%0d]", i), 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
    endtask

    // One clock: check grants and RAM drive mid-cycle, queue expected reads, advance.
    task automatic step(input logic eg0, input logic eg1, input logic [7:0] ex0, input logic [7:0] ex1);
        logic       ew;
        logic [7:0] ea, ed;
        @(negedge clka);
        ew = 1'b0; ea = 8'h00; ed = 8'h00;
        if (eg0) begin
            ew = m0_we; ea = m0_addr; ed = m0_wdata;
        end else if (eg1) begin
            ew = m1_we; ea = m1_addr; ed = m1_wdata;
        end
        chk("a_m0_gnt", 32'(a_m0_gnt), 32'(eg0));
        chk("a_m1_gnt", 32'(a_m1_gnt), 32'(eg1));
        chk("b_m0_gnt", 32'(b_m0_gnt), 32'(eg0));
        chk("b_m1_gnt", 32'(b_m1_gnt), 32'(eg1));
        chk("a_ram_wea", 32'(a_ram_wea), 32'(ew));
        chk("a_ram_addra", 32'(a_ram_addra), 32'(ea));
        chk("a_ram_dina", 32'(a_ram_dina), 32'(ed));
        chk("b_ram_wea", 32'(b_ram_wea), 32'(ew));
        chk("b_ram_addra", 32'(b_ram_addra), 32'(ea));
        chk("b_ram_dina", 32'(b_ram_dina), 32'(ed));
        if (eg0 && !m0_we) begin
            q[0].push_back('{ex0, cyc + 1});
            q[2].push_back('{ex0, cyc + 2});
        end
        if (eg1 && !m1_we) begin
            q[1].push_back('{ex1, cyc + 1});
            q[3].push_back('{ex1, cyc + 2});
        end
        @(posedge clka);
        #1;
    endtask

    task automatic chk_rvalid_low();
        chk("a_m0_rvalid_rst", 32'(a_m0_rvalid), 32'd0);
        chk("a_m1_rvalid_rst", 32'(a_m1_rvalid), 32'd0);
        chk("b_m0_rvalid_rst", 32'(b_m0_rvalid), 32'd0);
        chk("b_m1_rvalid_rst", 32'(b_m1_rvalid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) step(1'b0, 1'b0, 8'h00, 8'h00);
        chk_rvalid_low();
        rst_n = 1'b1;

        // Contested writes straight out of reset
        set0(1'b1, 1'b1, 8'h80, 8'h01);
        set1(1'b1, 1'b1, 8'h81, 8'h02);
        for (int i = 0; i < 4; i++) begin
            step(FIXED || ((i % 2) == 0), !FIXED && ((i % 2) == 1), 8'h00, 8'h00);
        end
        set1(1'b0, 1'b0, 8'h00, 8'h00);

        // m0 write then read of 0x0F
        set0(1'b1, 1'b1, 8'h0F, 8'hAA); step(1'b1, 1'b0, 8'h00, 8'h00);
        set0(1'b1, 1'b0, 8'h0F, 8'h00); step(1'b1, 1'b0, 8'hAA, 8'h00);
        set0(1'b0, 1'b0, 8'h00, 8'h00); step(1'b0, 1'b0, 8'h00, 8'h00);

        // Preloads: 0x55 <- 0x33 by m1, 0..3 <- 0x10..0x13 by m0
        set1(1'b1, 1'b1, 8'h55, 8'h33); step(1'b0, 1'b1, 8'h00, 8'h00);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 1'b1, 8'(i), 8'(8'h10 + i));
            step(1'b1, 1'b0, 8'h00, 8'h00);
        end

        // Back-to-back reads from different masters
        set0(1'b1, 1'b0, 8'h0F, 8'h00); step(1'b1, 1'b0, 8'hAA, 8'h00);
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        set1(1'b1, 1'b0, 8'h55, 8'h00); step(1'b0, 1'b1, 8'h00, 8'h33);

        // Streamed m1 reads
        for (int i = 0; i < 4; i++) begin
            set1(1'b1, 1'b0, 8'(i), 8'h00);
            step(1'b0, 1'b1, 8'h00, 8'(8'h10 + i));
        end

        // m1 write followed immediately by m0 read of the same address
        set1(1'b1, 1'b1, 8'h20, 8'h5A); step(1'b0, 1'b1, 8'h00, 8'h00);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        set0(1'b1, 1'b0, 8'h20, 8'h00); step(1'b1, 1'b0, 8'h5A, 8'h00);
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) step(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset lands one cycle after a granted read: its response is discarded
        set0(1'b1, 1'b0, 8'h0F, 8'h00); step(1'b1, 1'b0, 8'hAA, 8'h00);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        set1(1'b1, 1'b0, 8'h55, 8'h00);
        repeat (2) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            chk_rvalid_low();
        end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'hAA, 8'h00);
        set0(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h33);
        set1(1'b0, 1'b0, 8'h00, 8'h00);
        repeat (4) step(1'b0, 1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pending[%0d]", i), 32'(q[i].size()), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
